// File: rtl/transmission_sched_pkg.sv
// Shared types and defaults for the transmission scheduler.
// Holds the FSM state encoding, the default field width and a saturating increment helper.
package transmission_sched_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } sched_state_e;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v
  );
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/transmission_scheduler_down_counter.sv
// sched_down_counter: loadable down counter that holds at zero.
// Ports: clk_in, rst_n_in, load/load_val, dec, count, zero.
module sched_down_counter #(
  parameter int W = 16
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/transmission_scheduler.sv
// Burst/gap trigger scheduler with fifo backpressure and stop/abort.
// Ports: clk_in, rst_n_in, start_in, stop_in, burst_len_in, gap_len_in,
//   num_bursts_in, fifo_afull_in -> trigger_out, busy_out, done_out,
//   word_cnt_out, stall_cnt_out. Macro TRANSMISSION_SCHED_STATS_EN
//   enables the two statistics counters (tied to 0 otherwise).
module transmission_scheduler
  import transmission_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic             stop_in,
  input  logic [CNT_W-1:0] burst_len_in,
  input  logic [CNT_W-1:0] gap_len_in,
  input  logic [CNT_W-1:0] num_bursts_in,
  input  logic             fifo_afull_in,
  output logic             trigger_out,
  output logic             busy_out,
  output logic             done_out,
  output logic [31:0]      word_cnt_out,
  output logic [31:0]      stall_cnt_out
);

  // Async assert, release synchronised to clk_in.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rst_sync <= '0;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] blen_q, glen_q;
  logic             cont_q;
  logic             trig_d, trig_q;
  logic             fin_d, fin_q, done_q;
  logic             accept, issue, stall;

  logic             rem_ld, rem_dec, rem_zero;
  logic [CNT_W-1:0] rem_val, rem_cnt;
  logic             gap_ld, gap_dec, gap_zero;
  logic [CNT_W-1:0] gap_cnt;
  logic             bc_ld, bc_dec, bc_zero;
  logic [CNT_W-1:0] bc_cnt;
  logic             more;

  // Counters hold "remaining minus one", so zero marks the final step.
  sched_down_counter #(.W(CNT_W)) u_rem (
    .clk_in   (clk_in),
    .rst_n_in (rst_n),
    .load     (rem_ld),
    .load_val (rem_val),
    .dec      (rem_dec),
    .count    (rem_cnt),
    .zero     (rem_zero)
  );

  sched_down_counter #(.W(CNT_W)) u_gap (
    .clk_in   (clk_in),
    .rst_n_in (rst_n),
    .load     (gap_ld),
    .load_val (glen_q - CNT_W'(1)),
    .dec      (gap_dec),
    .count    (gap_cnt),
    .zero     (gap_zero)
  );

  sched_down_counter #(.W(CNT_W)) u_bc (
    .clk_in   (clk_in),
    .rst_n_in (rst_n),
    .load     (bc_ld),
    .load_val (num_bursts_in - CNT_W'(1)),
    .dec      (bc_dec),
    .count    (bc_cnt),
    .zero     (bc_zero)
  );

  assign more = cont_q || !bc_zero;

  always_comb begin
    state_d = state_q;
    rem_ld  = 1'b0;
    rem_val = blen_q - CNT_W'(1);
    rem_dec = 1'b0;
    gap_ld  = 1'b0;
    gap_dec = 1'b0;
    bc_ld   = 1'b0;
    bc_dec  = 1'b0;
    trig_d  = 1'b0;
    fin_d   = 1'b0;
    accept  = 1'b0;
    issue   = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_in && !stop_in &&
            burst_len_in != '0) begin
          accept  = 1'b1;
          state_d = BURST;
          rem_ld  = 1'b1;
          rem_val = burst_len_in - CNT_W'(1);
          bc_ld   = 1'b1;
        end
      end
      BURST: begin
        if (stop_in) begin
          state_d = IDLE;
          fin_d   = 1'b1;
        end else if (fifo_afull_in) begin
          stall = 1'b1;
        end else begin
          issue  = 1'b1;
          trig_d = 1'b1;
          if (!rem_zero) begin
            rem_dec = 1'b1;
          end else if (more) begin
            bc_dec = !cont_q;
            if (glen_q != '0) begin
              state_d = GAP;
              gap_ld  = 1'b1;
            end else begin
              rem_ld = 1'b1;
            end
          end else begin
            state_d = IDLE;
            fin_d   = 1'b1;
          end
        end
      end
      GAP: begin
        if (stop_in) begin
          state_d = IDLE;
          fin_d   = 1'b1;
        end else if (gap_zero) begin
          state_d = BURST;
          rem_ld  = 1'b1;
        end else begin
          gap_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // done_out trails the end of the run by one cycle.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      blen_q  <= '0;
      glen_q  <= '0;
      cont_q  <= 1'b0;
      trig_q  <= 1'b0;
      fin_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q  <= trig_d;
      fin_q   <= fin_d;
      done_q  <= fin_q;
      if (accept) begin
        blen_q <= burst_len_in;
        glen_q <= gap_len_in;
        cont_q <= (num_bursts_in == '0);
      end
    end
  end

  assign trigger_out = trig_q;
  assign busy_out    = (state_q != IDLE);
  assign done_out    = done_q;

`ifdef TRANSMISSION_SCHED_STATS_EN
  logic [31:0] word_q, stall_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      stall_q <= '0;
    end else if (accept) begin
      word_q  <= '0;
      stall_q <= '0;
    end else begin
      if (issue) word_q  <= word_q + 32'd1;
      if (stall) stall_q <= sat_inc(stall_q);
    end
  end

  assign word_cnt_out  = word_q;
  assign stall_cnt_out = stall_q;
`else
  logic unused_stats;
  assign unused_stats  = issue ^ stall;
  assign word_cnt_out  = '0;
  assign stall_cnt_out = '0;
`endif

  logic unused_cnt;
  assign unused_cnt = ^{rem_cnt, gap_cnt, bc_cnt};

endmodule

// File: tb/tb_transmission_scheduler.sv
// Self-checking bench for transmission_scheduler.
// Behavioural model plus directed runs with literal masks.
module tb_transmission_scheduler;

  localparam int W = 16;

  logic         clk_in = 1'b0;
  logic         rst_n_in = 1'b1;
  logic         start_in = 1'b0;
  logic         stop_in = 1'b0;
  logic [W-1:0] burst_len_in = '0;
  logic [W-1:0] gap_len_in = '0;
  logic [W-1:0] num_bursts_in = '0;
  logic         fifo_afull_in = 1'b0;
  logic         trigger_out, busy_out, done_out;
  logic [31:0]  word_cnt_out, stall_cnt_out;

  transmission_scheduler #(.CNT_W(W)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .start_in      (start_in),
    .stop_in       (stop_in),
    .burst_len_in  (burst_len_in),
    .gap_len_in    (gap_len_in),
    .num_bursts_in (num_bursts_in),
    .fifo_afull_in (fifo_afull_in),
    .trigger_out   (trigger_out),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .word_cnt_out  (word_cnt_out),
    .stall_cnt_out (stall_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, exp);
    end
  endtask

  function automatic logic [31:0] st(input logic [31:0] v);
`ifdef TRANSMISSION_SCHED_STATS_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  // Model: phase 0 idle, 1 burst, 2 gap
  int          m_sc, m_ph, m_left, m_gap, m_bleft;
  int          m_bl, m_gl, m_nb;
  bit          m_trig, m_done, m_fin;
  logic [31:0] m_word, m_stall;

  task automatic model_reset();
    m_sc = 0; m_ph = 0; m_left = 0; m_gap = 0;
    m_bleft = 0; m_trig = 0; m_done = 0; m_fin = 0;
    m_word = 0; m_stall = 0;
  endtask

  task automatic model_step();
    m_done = m_fin;
    m_fin = 0;
    m_trig = 0;
    if (m_ph == 0) begin
      if (start_in && !stop_in && burst_len_in != 0) begin
        m_bl = int'(burst_len_in);
        m_gl = int'(gap_len_in);
        m_nb = int'(num_bursts_in);
        m_left = m_bl;
        m_bleft = m_nb;
        m_word = 0;
        m_stall = 0;
        m_ph = 1;
      end
    end else if (stop_in) begin
      m_ph = 0;
      m_fin = 1;
    end else if (m_ph == 1) begin
      if (fifo_afull_in) begin
        if (m_stall != 32'hFFFF_FFFF) m_stall++;
      end else begin
        m_trig = 1;
        m_word++;
        m_left--;
        if (m_left == 0) begin
          if (m_nb == 0 || m_bleft > 1) begin
            if (m_nb != 0) m_bleft--;
            if (m_gl > 0) begin
              m_ph = 2;
              m_gap = m_gl;
            end else begin
              m_left = m_bl;
            end
          end else begin
            m_ph = 0;
            m_fin = 1;
          end
        end
      end
    end else begin
      m_gap--;
      if (m_gap == 0) begin
        m_ph = 1;
        m_left = m_bl;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_in or negedge rst_n_in);
      if (!rst_n_in) model_reset();
      else if (m_sc < 2) m_sc++;
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk_in);
      if (chk_en) begin
        chk("trigger", {63'd0, trigger_out}, {63'd0, m_trig});
        chk("busy", {63'd0, busy_out}, {63'd0, m_ph != 0});
        chk("done", {63'd0, done_out}, {63'd0, m_done});
        chk("word_cnt", {32'd0, word_cnt_out}, {32'd0, st(m_word)});
        chk("stall_cnt", {32'd0, stall_cnt_out},
            {32'd0, st(m_stall)});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  // Call at a negedge; masks are indexed by cycle after start.
  task automatic run(input logic [W-1:0] bl, gl, nb,
                     input int ncyc,
                     input logic [31:0] amask, smask, pmask,
                     output logic [31:0] tm, dm, bm);
    burst_len_in = bl;
    gap_len_in = gl;
    num_bursts_in = nb;
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    burst_len_in = 16'd9;
    gap_len_in = 16'd5;
    num_bursts_in = 16'd3;
    tm = 0; dm = 0; bm = 0;
    for (int n = 0; n < ncyc; n++) begin
      tm[n] = trigger_out;
      dm[n] = done_out;
      bm[n] = busy_out;
      fifo_afull_in = amask[n];
      start_in = smask[n];
      stop_in = pmask[n];
      @(negedge clk_in);
    end
    fifo_afull_in = 1'b0;
    start_in = 1'b0;
    stop_in = 1'b0;
  endtask

  logic [31:0] tm, dm, bm;
  int          cnt;

  initial begin
    #1 rst_n_in = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("rst trigger", {63'd0, trigger_out}, 64'd0);
    chk("rst busy", {63'd0, busy_out}, 64'd0);
    rst_n_in = 1'b1;
    repeat (4) @(negedge clk_in);

    run(4, 2, 2, 14, 0, 0, 0, tm, dm, bm);
    chk("r32 trig mask", {32'd0, tm}, 64'h79E);
    chk("r32 done mask", {32'd0, dm}, 64'h800);
    chk("r32 busy mask", {32'd0, bm}, 64'h3FF);
    chk("r32 word", {32'd0, word_cnt_out}, {32'd0, st(8)});

    run(3, 0, 1, 9, 32'h6, 0, 0, tm, dm, bm);
    chk("r33 trig mask", {32'd0, tm}, 64'h32);
    chk("r33 done mask", {32'd0, dm}, 64'h40);
    chk("r33 busy mask", {32'd0, bm}, 64'h1F);
    chk("r33 stall", {32'd0, stall_cnt_out}, {32'd0, st(2)});
    chk("r33 word", {32'd0, word_cnt_out}, {32'd0, st(3)});

    run(1, 1, 0, 13, 0, 0, 32'h200, tm, dm, bm);
    chk("r34 trig mask", {32'd0, tm}, 64'h2AA);
    chk("r34 done mask", {32'd0, dm}, 64'h800);
    chk("r34 busy mask", {32'd0, bm}, 64'h3FF);
    chk("r34 word", {32'd0, word_cnt_out}, {32'd0, st(5)});

    run(0, 2, 1, 5, 0, 0, 0, tm, dm, bm);
    chk("zero len trig", {32'd0, tm}, 64'd0);
    chk("zero len busy", {32'd0, bm}, 64'd0);

    stop_in = 1'b1;
    run(2, 0, 1, 5, 0, 0, 0, tm, dm, bm);
    chk("start+stop busy", {32'd0, bm}, 64'd0);
    chk("start+stop trig", {32'd0, tm}, 64'd0);

    run(2, 3, 2, 10, 0, 32'h1, 0, tm, dm, bm);
    chk("restart trig mask", {32'd0, tm}, 64'hC6);
    chk("restart done mask", {32'd0, dm}, 64'h100);
    chk("restart busy mask", {32'd0, bm}, 64'h7F);

    run(2, 0, 2, 7, 0, 0, 0, tm, dm, bm);
    chk("gap0 trig mask", {32'd0, tm}, 64'h1E);
    chk("gap0 done mask", {32'd0, dm}, 64'h20);

    burst_len_in = 16'd10;
    gap_len_in = 16'd0;
    num_bursts_in = 16'd1;
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    repeat (5) @(negedge clk_in);
    chk("pre-rst word", {32'd0, word_cnt_out}, {32'd0, st(5)});
    chk("pre-rst busy", {63'd0, busy_out}, 64'd1);
    #1 rst_n_in = 1'b0;
    #1;
    chk("mid rst trigger", {63'd0, trigger_out}, 64'd0);
    chk("mid rst busy", {63'd0, busy_out}, 64'd0);
    chk("mid rst done", {63'd0, done_out}, 64'd0);
    chk("mid rst word", {32'd0, word_cnt_out}, 64'd0);
    chk("mid rst stall", {32'd0, stall_cnt_out}, 64'd0);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (trigger_out || busy_out) cnt++;
    end
    chk("post-rst idle", cnt, 0);

`ifdef TRANSMISSION_SCHED_STATS_EN
    burst_len_in = 16'd3;
    gap_len_in = 16'd0;
    num_bursts_in = 16'd1;
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    #1;
    force dut.word_q = 32'hFFFF_FFFF;
    m_word = 32'hFFFF_FFFF;
    #1;
    release dut.word_q;
    @(negedge clk_in);
    chk("word wrap", {32'd0, word_cnt_out}, 64'd0);
    repeat (6) @(negedge clk_in);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/transmission_scheduler.md
TRANSMISSION_SCHEDULER -- requirements
Module: transmission_scheduler

Interface
REQ-001 SHALL have parameter CNT_W, 16, width of burst length, gap length and burst count fields.
REQ-002 SHALL have port clk_in  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst_n_in  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start_in  input  1  one-cycle start request.
REQ-005 SHALL have port stop_in  input  1  one-cycle abort request.
REQ-006 SHALL have port burst_len_in  input  CNT_W  triggers per burst.
REQ-007 SHALL have port gap_len_in  input  CNT_W  idle cycles between bursts.
REQ-008 SHALL have port num_bursts_in  input  CNT_W  burst count; 0 = continuous.
REQ-009 SHALL have port fifo_afull_in  input  1  downstream almost-full backpressure.
REQ-010 SHALL have port trigger_out  output  1  registered trigger to the pattern generator.
REQ-011 SHALL have port busy_out  output  1  high in any state other than IDLE.
REQ-012 SHALL have port done_out  output  1  one-cycle completion/abort pulse.
REQ-013 SHALL have port word_cnt_out  output  32  triggers issued since the last start.
REQ-014 SHALL have port stall_cnt_out  output  32  BURST cycles blocked by fifo_afull_in.

Function
REQ-015 SHALL implement states IDLE, BURST and GAP.
REQ-016 In IDLE, start_in with burst_len_in != 0 SHALL latch burst_len_in, gap_len_in and num_bursts_in, clear both counters and enter BURST on the next edge; start_in with burst_len_in == 0 SHALL be ignored.
REQ-017 In BURST, at each edge where fifo_afull_in is low and remaining triggers > 0, trigger_out SHALL be high in the following cycle and the remaining-trigger count SHALL decrement; otherwise trigger_out SHALL be low.
REQ-018 A fifo_afull_in stall SHALL only hold the burst: no trigger is issued or lost, and the remaining count is unchanged.
REQ-019 When the last trigger of a burst is issued, the state SHALL become GAP if gap_len > 0 and bursts remain, BURST (reloaded) if gap_len == 0 and bursts remain, otherwise IDLE with done_out pulsed.
REQ-020 GAP SHALL last exactly gap_len cycles with trigger_out low, then reload the burst length and re-enter BURST.
REQ-021 num_bursts == 0 SHALL run bursts indefinitely until stop_in.
REQ-022 stop_in in BURST or GAP SHALL force IDLE on the next edge, deassert trigger_out in that cycle and pulse done_out once.
REQ-023 start_in while busy SHALL be ignored; start_in and stop_in together in IDLE SHALL be ignored (stop wins).
REQ-024 word_cnt_out SHALL increment once per issued trigger and wrap from 0xFFFFFFFF to 0; stall_cnt_out SHALL increment once per stalled BURST cycle and saturate at 0xFFFFFFFF.
REQ-025 Inputs changed while busy SHALL NOT affect the run in progress.

Reset
REQ-026 Asserting rst_n_in low SHALL immediately force IDLE, trigger_out=0, busy_out=0, done_out=0, word_cnt_out=0 and stall_cnt_out=0, including in the middle of a burst.
REQ-027 Release of rst_n_in SHALL be synchronised to clk_in, and no trigger SHALL issue before a new start_in.

Configuration
REQ-028 With macro TRANSMISSION_SCHED_STATS_EN defined, word_cnt_out and stall_cnt_out SHALL be driven per REQ-024.
REQ-029 Without TRANSMISSION_SCHED_STATS_EN, both counters SHALL be omitted and their outputs tied to 0; all other behaviour SHALL be identical.

Structure
REQ-030 Package transmission_sched_pkg SHALL hold the state encoding constants (IDLE=2'd0, BURST=2'd1, GAP=2'd2) and the default value of CNT_W.
REQ-031 The remaining-trigger, gap and burst counters SHALL use one reusable sub-module, sched_down_counter (load, decrement-enable, zero flag).

Verification
REQ-032 burst_len=4, gap=2, num_bursts=2, afull=0, start -> triggers high on cycles 1-4 and 7-10 after start, done pulse at cycle 11, word_cnt=8.
REQ-033 burst_len=3, gap=0, num_bursts=1, afull high for 2 cycles in mid-burst -> exactly 3 triggers, stall_cnt=2, done pulse after the 3rd trigger.
REQ-034 num_bursts=0, burst_len=1, gap=1, stop after 10 cycles -> alternating trigger pattern, trigger low the cycle after stop, one done pulse, busy=0.
REQ-035 burst_len=0 start -> busy stays 0 and no triggers; second start while busy -> no effect.
REQ-036 rst_n_in low during BURST with word_cnt=5 -> outputs zero immediately; after release, no trigger until start.
REQ-037 Preload word_cnt to 0xFFFFFFFF (STATS_EN) and issue one trigger -> word_cnt_out=0.
